// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
// Bundles every decode-side, producer-side and EX-side signal of the
// ID/EX pipeline register so the stage and its surroundings connect through one port.
//   master : decode / MEM / WB side (drives instruction and producer info,
//            observes id_ready and the EX register)
//   slave  : the id_ex_stage itself
// Parameters: DATA_W operand width, REG_AW register address width,
//             CTRL_W ALU control width.

interface id_ex_stage_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) ();
    // decode side
    logic              id_valid;
    logic              id_ready;
    logic              flush;
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_alu_src;
    logic [CTRL_W-1:0] id_alu_ctrl;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;

    // downstream producers
    logic              mem_reg_write;
    logic [REG_AW-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_result;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd_addr;
    logic [DATA_W-1:0] wb_result;

    // EX register
    logic              ex_valid;
    logic [DATA_W-1:0] ALU_operand_1;
    logic [DATA_W-1:0] ALU_operand_2;
    logic [CTRL_W-1:0] ALU_ctrl_input;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;

    modport master (
        output id_valid, flush, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_ctrl,
               id_reg_write, id_mem_read, id_mem_write,
               mem_reg_write, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_result,
        input  id_ready, ex_valid, ALU_operand_1, ALU_operand_2, ALU_ctrl_input,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, flush, id_rs_addr, id_rt_addr, id_rd_addr,
               id_rs_data, id_rt_data, id_imm, id_alu_src, id_alu_ctrl,
               id_reg_write, id_mem_read, id_mem_write,
               mem_reg_write, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_result,
        output id_ready, ex_valid, ALU_operand_1, ALU_operand_2, ALU_ctrl_input,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode-to-execute pipeline register of the 8-bit MIPS pipeline. Captures
// the decoded instruction, forwards operands from MEM/WB, and stalls decode
// (inserting a bubble into EX) on a data hazard. A flush also inserts a bubble.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high (EX loads a bubble)
//   bus  id_ex_stage_if.slave: decode inputs, MEM/WB producer inputs,
//        id_ready and the registered EX outputs
//
// Build option:
//   ID_EX_FWD_EN  defined   -> operands forwarded from MEM (priority) then WB;
//                              only load-use stalls.
//                 undefined -> operands taken straight from the register file;
//                              stall on any dependency against EX or MEM.
//
// Bubble contents: everything zero except ALU_ctrl_input = ADD, so the
// ALU quietly computes 0+0.

module id_ex_stage #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 4
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [DATA_W-1:0] store;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    function automatic ex_t bubble_val();
        ex_t b;
        b      = '0;
        b.ctrl = CTRL_W'(4'b0010);
        return b;
    endfunction

    ex_t               ex_q;
    ex_t               ex_d;
    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;
    logic              rt_used;
    logic              hazard;

    assign rt_used = !bus.id_alu_src || bus.id_mem_write;

    // Operand selection
    always_comb begin
        fa = bus.id_rs_data;
        fb = bus.id_rt_data;
`ifdef ID_EX_FWD_EN
        // WB first, then MEM overrides it: MEM holds the younger value.
        if (bus.wb_reg_write && bus.wb_rd_addr == bus.id_rs_addr && bus.id_rs_addr != '0)
            fa = bus.wb_result;
        if (bus.mem_reg_write && bus.mem_rd_addr == bus.id_rs_addr && bus.id_rs_addr != '0)
            fa = bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd_addr == bus.id_rt_addr && bus.id_rt_addr != '0)
            fb = bus.wb_result;
        if (bus.mem_reg_write && bus.mem_rd_addr == bus.id_rt_addr && bus.id_rt_addr != '0)
            fb = bus.mem_result;
`endif
    end

    // Hazard detection
`ifdef ID_EX_FWD_EN
    logic load_in_ex;
    logic ex_dep;

    // Only a load in EX cannot be forwarded in time; one bubble moves it
    // along far enough for the forwarding paths to pick it up.
    assign load_in_ex = ex_q.valid && ex_q.mem_read && ex_q.rd != '0;
    assign ex_dep     = (bus.id_rs_addr == ex_q.rd) ||
                        (rt_used && bus.id_rt_addr == ex_q.rd);
    assign hazard     = bus.id_valid && load_in_ex && ex_dep;
`else
    logic ex_prod;
    logic mem_prod;
    logic ex_dep;
    logic mem_dep;
    logic fwd_unused;

    // Without forwarding, wait until the producer has left EX and MEM. WB is
    // safe because the register file writes before it is read.
    assign ex_prod  = ex_q.valid && ex_q.reg_write && ex_q.rd != '0;
    assign mem_prod = bus.mem_reg_write && bus.mem_rd_addr != '0;
    assign ex_dep   = (bus.id_rs_addr == ex_q.rd) ||
                      (rt_used && bus.id_rt_addr == ex_q.rd);
    assign mem_dep  = (bus.id_rs_addr == bus.mem_rd_addr) ||
                      (rt_used && bus.id_rt_addr == bus.mem_rd_addr);
    assign hazard   = bus.id_valid && ((ex_prod && ex_dep) || (mem_prod && mem_dep));

    assign fwd_unused = ^{bus.mem_result, bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result};
`endif

    assign bus.id_ready = !hazard;

    // Next EX contents: flush and hazard both force a bubble, even with a
    // valid decode instruction; a hazard additionally holds decode.
    always_comb begin
        ex_d = bubble_val();
        if (!bus.flush && !hazard && bus.id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
            ex_d.mem_write = bus.id_mem_write;
            ex_d.rd        = bus.id_rd_addr;
            ex_d.op1       = fa;
            ex_d.op2       = bus.id_alu_src ? bus.id_imm : fb;
            ex_d.store     = fb;
            ex_d.ctrl      = bus.id_alu_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ex_q <= bubble_val();
        else
            ex_q <= ex_d;
    end

    assign bus.ex_valid       = ex_q.valid;
    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_rd_addr     = ex_q.rd;
    assign bus.ALU_operand_1  = ex_q.op1;
    assign bus.ALU_operand_2  = ex_q.op2;
    assign bus.ex_store_data  = ex_q.store;
    assign bus.ALU_ctrl_input = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized instructions, all checked against a behavioural model of the
// EX register. Honours ID_EX_FWD_EN the same way the design does.

module tb_id_ex_stage;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int CW = 4;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) bus ();

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       valid, rw, mr, mw;
        logic [4:0] rd;
        logic [7:0] op1, op2, sd;
        logic [3:0] ctrl;
    } ex_m_t;

    int    tests = 0;
    int    fails = 0;
    ex_m_t m;

    function automatic ex_m_t bubble();
        ex_m_t b;
        b      = '0;
        b.ctrl = ADD;
        return b;
    endfunction

    // Value decode would see for register a: youngest in-flight producer
    // (MEM, then WB) wins; register 0 always reads the file.
    function automatic logic [7:0] model_operand(logic [4:0] a, logic [7:0] rf);
`ifdef ID_EX_FWD_EN
        if (a != 0) begin
            if (bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_result;
            if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_result;
        end
`endif
        return rf;
    endfunction

    function automatic bit reads_reg(logic [4:0] r);
        bit rt_used;
        rt_used = !bus.id_alu_src || bus.id_mem_write;
        return r != 0 && (bus.id_rs_addr == r || (rt_used && bus.id_rt_addr == r));
    endfunction

    function automatic bit model_stall();
        if (!bus.id_valid) return 0;
`ifdef ID_EX_FWD_EN
        return m.valid && m.mr && reads_reg(m.rd);
`else
        return (m.valid && m.rw && reads_reg(m.rd)) ||
               (bus.mem_reg_write && reads_reg(bus.mem_rd_addr));
`endif
    endfunction

    function automatic ex_m_t model_next(bit stall);
        ex_m_t n;
        logic [7:0] b;
        n = bubble();
        if (!bus.flush && !stall && bus.id_valid) begin
            b       = model_operand(bus.id_rt_addr, bus.id_rt_data);
            n.valid = 1;
            n.rw    = bus.id_reg_write;
            n.mr    = bus.id_mem_read;
            n.mw    = bus.id_mem_write;
            n.rd    = bus.id_rd_addr;
            n.op1   = model_operand(bus.id_rs_addr, bus.id_rs_data);
            n.op2   = bus.id_alu_src ? bus.id_imm : b;
            n.sd    = b;
            n.ctrl  = bus.id_alu_ctrl;
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ex(string tag);
        chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(m.valid));
        chk({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(m.rw));
        chk({tag, ".ex_mem_read"}, 32'(bus.ex_mem_read), 32'(m.mr));
        chk({tag, ".ex_mem_write"}, 32'(bus.ex_mem_write), 32'(m.mw));
        chk({tag, ".ex_rd_addr"}, 32'(bus.ex_rd_addr), 32'(m.rd));
        chk({tag, ".op1"}, 32'(bus.ALU_operand_1), 32'(m.op1));
        chk({tag, ".op2"}, 32'(bus.ALU_operand_2), 32'(m.op2));
        chk({tag, ".store"}, 32'(bus.ex_store_data), 32'(m.sd));
        chk({tag, ".ctrl"}, 32'(bus.ALU_ctrl_input), 32'(m.ctrl));
    endtask

    // One clock: check id_ready, clock the edge, check the EX register.
    task automatic cycle(string tag);
        bit    stall;
        ex_m_t nxt;
        #1;
        stall = model_stall();
        chk({tag, ".id_ready"}, 32'(bus.id_ready), 32'(!stall));
        nxt = model_next(stall);
        @(posedge clk);
        #1;
        m = nxt;
        check_ex(tag);
    endtask

    task automatic set_idle();
        bus.id_valid      = 0; bus.flush        = 0;
        bus.id_rs_addr    = 0; bus.id_rt_addr   = 0; bus.id_rd_addr = 0;
        bus.id_rs_data    = 0; bus.id_rt_data   = 0; bus.id_imm     = 0;
        bus.id_alu_src    = 0; bus.id_alu_ctrl  = ADD;
        bus.id_reg_write  = 0; bus.id_mem_read  = 0; bus.id_mem_write = 0;
        bus.mem_reg_write = 0; bus.mem_rd_addr  = 0; bus.mem_result = 0;
        bus.wb_reg_write  = 0; bus.wb_rd_addr   = 0; bus.wb_result  = 0;
    endtask

    task automatic set_instr(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                             logic [7:0] rsd, logic [7:0] rtd, logic [7:0] imm,
                             logic src, logic [3:0] ctrl, logic rw, logic mr, logic mw);
        bus.id_valid     = 1;
        bus.id_rs_addr   = rs;  bus.id_rt_addr  = rt;  bus.id_rd_addr = rd;
        bus.id_rs_data   = rsd; bus.id_rt_data  = rtd; bus.id_imm     = imm;
        bus.id_alu_src   = src; bus.id_alu_ctrl = ctrl;
        bus.id_reg_write = rw;  bus.id_mem_read = mr;  bus.id_mem_write = mw;
    endtask

    initial begin
        // reset
        set_idle();
        rst = 1;
        #12;
        m = bubble();
        check_ex("reset");
        chk("reset.id_ready", 32'(bus.id_ready), 32'd1);
        rst = 0;

        // ADD r3 = r1 + r2
        set_instr(1, 2, 3, 8'd5, 8'd7, 8'h00, 0, ADD, 1, 0, 0);
        cycle("add");
        chk("add.op1_const", 32'(bus.ALU_operand_1), 32'd5);
        chk("add.op2_const", 32'(bus.ALU_operand_2), 32'd7);
        chk("add.rd_const", 32'(bus.ex_rd_addr), 32'd3);
        chk("add.ctrl_const", 32'(bus.ALU_ctrl_input), 32'(ADD));

        // reset in the middle of a capture cycle
        set_instr(1, 2, 4, 8'd9, 8'd1, 8'h00, 0, SUB, 1, 0, 0);
        #2 rst = 1;
        #1;
        m = bubble();
        check_ex("rst_mid");
        chk("rst_mid.ctrl_const", 32'(bus.ALU_ctrl_input), 32'(ADD));
        rst = 0;
        cycle("after_rst");

        // forwarding priority on rs = r4
        set_instr(4, 5, 8, 8'h44, 8'h55, 8'h00, 0, ADD, 1, 0, 0);
        bus.mem_reg_write = 1; bus.mem_rd_addr = 4; bus.mem_result = 8'h11;
        bus.wb_reg_write  = 1; bus.wb_rd_addr  = 4; bus.wb_result  = 8'h22;
        cycle("fwd_mem");
`ifdef ID_EX_FWD_EN
        chk("fwd_mem.op1_const", 32'(bus.ALU_operand_1), 32'h11);
`endif
        bus.mem_reg_write = 0;
        cycle("fwd_wb");
`ifdef ID_EX_FWD_EN
        chk("fwd_wb.op1_const", 32'(bus.ALU_operand_1), 32'h22);
`endif
        // r0 never forwarded
        set_instr(0, 0, 8, 8'h44, 8'h55, 8'h00, 0, ADD, 1, 0, 0);
        bus.mem_reg_write = 1; bus.mem_rd_addr = 0;
        bus.wb_reg_write  = 1; bus.wb_rd_addr  = 0;
        cycle("fwd_r0");
        chk("fwd_r0.op1_const", 32'(bus.ALU_operand_1), 32'h44);
        set_idle();
        cycle("idle");

        // load-use: lw r6, then SUB r7 = r6 - r1
        set_instr(1, 2, 6, 8'h10, 8'h00, 8'h04, 1, ADD, 1, 1, 0);
        cycle("lw");
        set_instr(6, 1, 7, 8'h99, 8'h0A, 8'h00, 0, SUB, 1, 0, 0);
        #1 chk("lu.id_ready_const", 32'(bus.id_ready), 32'd0);
        cycle("lu_stall");
        chk("lu_stall.valid_const", 32'(bus.ex_valid), 32'd0);
        bus.wb_reg_write = 1; bus.wb_rd_addr = 6; bus.wb_result = 8'h33;
        cycle("lu_go");
        chk("lu_go.valid_const", 32'(bus.ex_valid), 32'd1);
`ifdef ID_EX_FWD_EN
        chk("lu_go.op1_const", 32'(bus.ALU_operand_1), 32'h33);
`else
        chk("lu_go.op1_const", 32'(bus.ALU_operand_1), 32'h99);
`endif

        // flush with a valid instruction
        set_idle();
        set_instr(1, 2, 3, 8'd5, 8'd7, 8'h00, 0, ADD, 1, 0, 1);
        bus.flush = 1;
        cycle("flush");
        chk("flush.valid_const", 32'(bus.ex_valid), 32'd0);
        chk("flush.rw_const", 32'(bus.ex_reg_write), 32'd0);
        bus.flush = 0;

        // flush together with a load-use hazard
        set_instr(1, 2, 6, 8'h10, 8'h00, 8'h04, 1, ADD, 1, 1, 0);
        cycle("lw2");
        set_instr(3, 6, 7, 8'h01, 8'h02, 8'h00, 0, SUB, 1, 0, 0);
        bus.flush = 1;
        #1 chk("flush_hz.id_ready_const", 32'(bus.id_ready), 32'd0);
        cycle("flush_hz");
        chk("flush_hz.valid_const", 32'(bus.ex_valid), 32'd0);
        bus.flush = 0;

        // reset during a stall releases decode at once
        set_instr(1, 2, 6, 8'h10, 8'h00, 8'h04, 1, ADD, 1, 1, 0);
        cycle("lw3");
        set_instr(6, 1, 7, 8'h01, 8'h02, 8'h00, 0, SUB, 1, 0, 0);
        #1 chk("rst_stall.pre_ready", 32'(bus.id_ready), 32'd0);
        rst = 1;
        #1;
        m = bubble();
        chk("rst_stall.id_ready", 32'(bus.id_ready), 32'd1);
        check_ex("rst_stall");
        rst = 0;
        cycle("rst_stall_go");

`ifndef ID_EX_FWD_EN
        // no forwarding: ADD r2 then SUB on r2 stalls twice
        set_idle();
        set_instr(1, 3, 2, 8'd1, 8'd2, 8'h00, 0, ADD, 1, 0, 0);
        cycle("nf_add");
        set_instr(2, 3, 5, 8'h5A, 8'h02, 8'h00, 0, SUB, 1, 0, 0);
        cycle("nf_stall_ex");
        chk("nf_stall_ex.valid_const", 32'(bus.ex_valid), 32'd0);
        bus.mem_reg_write = 1; bus.mem_rd_addr = 2; bus.mem_result = 8'h03;
        cycle("nf_stall_mem");
        chk("nf_stall_mem.valid_const", 32'(bus.ex_valid), 32'd0);
        bus.mem_reg_write = 0;
        bus.wb_reg_write = 1; bus.wb_rd_addr = 2; bus.wb_result = 8'h03;
        cycle("nf_go");
        chk("nf_go.valid_const", 32'(bus.ex_valid), 32'd1);
        chk("nf_go.op1_const", 32'(bus.ALU_operand_1), 32'h5A);
`endif

        // randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 400; i++) begin
            set_instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                      1'($urandom_range(0, 3) == 0));
            bus.id_valid      = ($urandom_range(0, 3) != 0);
            bus.flush         = ($urandom_range(0, 9) == 0);
            bus.mem_reg_write = 1'($urandom);
            bus.mem_rd_addr   = 5'($urandom_range(0, 3));
            bus.mem_result    = 8'($urandom);
            bus.wb_reg_write  = 1'($urandom);
            bus.wb_rd_addr    = 5'($urandom_range(0, 3));
            bus.wb_result     = 8'($urandom);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
